// File: rtl/alu_muldiv_sequencer_pkg.sv
// Shared definitions for the multiply/divide sequencer: ALU funct codes and FSM states.
// The funct codes must stay in step with the ALU decoder.
package alu_muldiv_sequencer_pkg;

  localparam logic [5:0] FUNCT_MULT = 6'b011000;
  localparam logic [5:0] FUNCT_DIV  = 6'b011010;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  function automatic logic is_muldiv_funct(input logic [5:0] funct);
    return (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
  endfunction

endpackage

// File: rtl/alu_muldiv_sequencer_if.sv
// Request/result bundle between the execute stage (master) and the mul/div sequencer (slave).
interface alu_muldiv_sequencer_if #(parameter int WIDTH = 32);

  logic             start;
  logic [5:0]       funct;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (output start, funct, op_a, op_b,
                  input  busy, done, hi, lo, div_by_zero);

  modport slave  (input  start, funct, op_a, op_b,
                  output busy, done, hi, lo, div_by_zero);

endinterface

// File: rtl/alu_muldiv_sequencer_datapath.sv
// Magnitude datapath: shared 2*WIDTH register holding product (mult) or {remainder, dividend/quotient} (div),
// plus the sign fix-up that loads the HI/LO result registers.
module muldiv_datapath #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dz_load,
  input  logic             step,
  input  logic             fix,
  input  logic             op_is_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int W2 = 2 * WIDTH;

  logic [WIDTH-1:0] mag_q, mag_d;
  logic [W2-1:0]    prod_q, prod_d;
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   add_sum, sub_diff;
  logic [W2-1:0]    prod_neg;

  assign abs_a = op_a[WIDTH-1] ? -op_a : op_a;
  assign abs_b = op_b[WIDTH-1] ? -op_b : op_b;

  // mag holds the multiplicand for mult and the divisor for div; the other operand seeds the low half.
  always_comb begin
    add_sum   = {1'b0, prod_q[W2-1:WIDTH]} + {1'b0, mag_q};
    sub_diff  = prod_q[W2-1:WIDTH-1] - {1'b0, mag_q};
    prod_neg  = -prod_q;
    mag_d     = mag_q;
    prod_d    = prod_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    if (load) begin
      mag_d     = op_is_div ? abs_b : abs_a;
      prod_d    = {{WIDTH{1'b0}}, (op_is_div ? abs_a : abs_b)};
      is_div_d  = op_is_div;
      neg_res_d = op_a[WIDTH-1] ^ op_b[WIDTH-1];
      neg_rem_d = op_a[WIDTH-1];
    end else if (step) begin
      if (is_div_q) begin
        if (!sub_diff[WIDTH]) prod_d = {sub_diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
        else                  prod_d = {prod_q[W2-2:0], 1'b0};
      end else begin
        if (prod_q[0]) prod_d = {add_sum, prod_q[WIDTH-1:1]};
        else           prod_d = {1'b0, prod_q[W2-1:1]};
      end
    end

    if (fix) begin
      if (is_div_q) begin
        lo_d = neg_res_q ? -prod_q[WIDTH-1:0]  : prod_q[WIDTH-1:0];
        hi_d = neg_rem_q ? -prod_q[W2-1:WIDTH] : prod_q[W2-1:WIDTH];
      end else begin
        lo_d = neg_res_q ? prod_neg[WIDTH-1:0]  : prod_q[WIDTH-1:0];
        hi_d = neg_res_q ? prod_neg[W2-1:WIDTH] : prod_q[W2-1:WIDTH];
      end
    end else if (dz_load) begin
      hi_d = op_a;
      lo_d = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mag_q     <= '0;
      prod_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      mag_q     <= mag_d;
      prod_q    <= prod_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: rtl/alu_muldiv_sequencer.sv
// Multi-cycle mult/div controller beside the ALU: FSM, iteration counter and start/busy/done handshake.
// Owns the HI/LO registers through the datapath sub-module.
module alu_muldiv_sequencer
  import alu_muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic                   clk,
  input logic                   reset,
  alu_muldiv_sequencer_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic             accept, req_div, op_b_zero;
  logic             load, dz_load, step, fix;
  logic [WIDTH-1:0] hi, lo;

  // Divide by zero bypasses the iterations entirely and lands in DONE one cycle after acceptance.
  always_comb begin
    req_div   = (bus.funct == FUNCT_DIV);
    op_b_zero = (bus.op_b == '0);
    accept    = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE))
                && is_muldiv_funct(bus.funct);
    load      = accept && !(req_div && op_b_zero);
    dz_load   = accept && req_div && op_b_zero;
    step      = (state_q == ST_MUL) || (state_q == ST_DIV);
    fix       = (state_q == ST_FIX);

    state_d = state_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          dbz_d   = dz_load;
          state_d = dz_load ? ST_DONE : (req_div ? ST_DIV : ST_MUL);
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL, ST_DIV: begin
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = ST_FIX;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_FIX:  state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_MUL) || (state_d == ST_DIV) || (state_d == ST_FIX);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .dz_load   (dz_load),
    .step      (step),
    .fix       (fix),
    .op_is_div (req_div),
    .op_a      (bus.op_a),
    .op_b      (bus.op_b),
    .hi        (hi),
    .lo        (lo)
  );

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi;
  assign bus.lo          = lo;

endmodule
